// File: rtl/enc_chunk_bundler.sv
// Sparse HV bundler: sums bound HVs per dimension over a bundle, thresholds, streams result by chunk.
// Latency: NUM_CHUNKS cycles per input HV (one chunk per cycle); output is combinational from state.
// Backpressure: out_ready=0 freezes out_chunk/out_idx/ctr in EMIT indefinitely; upstream held until hv_ack.
//
// Ports: clk, rst (async active-high); start/thresh begin a bundle; hv_valid/hv_last/hv_ack handshake
// an input HV whose chunks arrive on chunk_in as selected by ctr; out_valid/out_ready/out_chunk/out_idx
// stream the thresholded bundle; busy (not idle), done (pulse after final output chunk accepted).
// Optional macro ENC_BUNDLE_DENSITY_EN adds a density output: popcount of the last emitted bundle.
module enc_chunk_bundler #(
    parameter int HV_DIM      = 5000,
    parameter int DIMS_PER_CC = 500,
    parameter int NUM_CHUNKS  = 10,
    parameter int CNT_W       = 6
`ifdef ENC_BUNDLE_DENSITY_EN
    ,
    parameter int DENS_W      = $clog2(HV_DIM + 1)
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       thresh,
    input  logic                   hv_valid,
    input  logic                   hv_last,
    output logic                   hv_ack,
    output logic [3:0]             ctr,
    input  logic [DIMS_PER_CC-1:0] chunk_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIMS_PER_CC-1:0] out_chunk,
    output logic [3:0]             out_idx,
    output logic                   busy,
    output logic                   done
`ifdef ENC_BUNDLE_DENSITY_EN
    ,
    output logic [DENS_W-1:0]      density
`endif
);

    localparam int IDX_W = $clog2(HV_DIM);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [3:0]       LAST_CHUNK = 4'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HV, ACCUM, EMIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] thresh_reg;
    logic             last_reg;
    logic [CNT_W-1:0] cnt [HV_DIM];

    // Flat counter index for bit i of chunk c.
    function automatic logic [IDX_W-1:0] cidx(input logic [3:0] c, input int i);
        return IDX_W'(int'(c) * DIMS_PER_CC + i);
    endfunction

    wire accept     = (state == EMIT) && out_ready;
    wire last_accept = accept && (ctr == LAST_CHUNK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ctr        <= 4'd0;
            thresh_reg <= '0;
            last_reg   <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < HV_DIM; k++) cnt[IDX_W'(k)] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < HV_DIM; k++) cnt[IDX_W'(k)] <= '0;
                        thresh_reg <= thresh;
                        state      <= WAIT_HV;
                    end
                end
                WAIT_HV: begin
                    ctr <= 4'd0;
                    if (hv_valid) begin
                        last_reg <= hv_last;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Saturating increment of every dimension set in this chunk.
                    for (int i = 0; i < DIMS_PER_CC; i++) begin
                        if (chunk_in[i] && (cnt[cidx(ctr, i)] != CNT_MAX))
                            cnt[cidx(ctr, i)] <= cnt[cidx(ctr, i)] + CNT_ONE;
                    end
                    if (ctr == LAST_CHUNK) begin
                        ctr   <= 4'd0;
                        state <= last_reg ? EMIT : WAIT_HV;
                    end else begin
                        ctr <= ctr + 4'd1;
                    end
                end
                EMIT: begin
                    if (last_accept) begin
                        ctr   <= 4'd0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (accept) begin
                        ctr <= ctr + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hv_ack    = (state == ACCUM) && (ctr == LAST_CHUNK);
    assign out_valid = (state == EMIT);
    assign out_idx   = out_valid ? ctr : 4'd0;
    assign busy      = (state != IDLE);

    always_comb begin
        out_chunk = '0;
        if (state == EMIT) begin
            for (int i = 0; i < DIMS_PER_CC; i++)
                out_chunk[i] = (cnt[cidx(ctr, i)] >= thresh_reg);
        end
    end

`ifdef ENC_BUNDLE_DENSITY_EN
    logic [DENS_W-1:0] pop;
    logic [DENS_W-1:0] dens_acc;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) pop = pop + DENS_W'(out_chunk[i]);
    end

    // Published on the same edge that raises done, so density is valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dens_acc <= '0;
            density  <= '0;
        end else if ((state == IDLE) && start) begin
            dens_acc <= '0;
            density  <= '0;
        end else if (accept) begin
            dens_acc <= dens_acc + pop;
            if (last_accept) density <= dens_acc + pop;
        end
    end
`endif

endmodule

// File: tb/tb_enc_chunk_bundler.sv
module tb_enc_chunk_bundler;

    localparam int DW   = 500;
    localparam int NCH  = 10;
    localparam int CW   = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] thresh;
    logic          hv_valid;
    logic          hv_last;
    logic          hv_ack;
    logic [3:0]    ctr;
    logic [DW-1:0] chunk_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_chunk;
    logic [3:0]    out_idx;
    logic          busy;
    logic          done;
`ifdef ENC_BUNDLE_DENSITY_EN
    logic [12:0]   density;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;

    enc_chunk_bundler dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh),
        .hv_valid(hv_valid), .hv_last(hv_last), .hv_ack(hv_ack), .ctr(ctr),
        .chunk_in(chunk_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_chunk(out_chunk), .out_idx(out_idx), .busy(busy), .done(done)
`ifdef ENC_BUNDLE_DENSITY_EN
        , .density(density)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // HV chunk patterns: 0 zeros, 1 ones, 2 bit i=(i+c)%2, 3 37 ones in chunk 3 only.
    function automatic logic [DW-1:0] pat(input int m, input int c);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW; i++) begin
            case (m)
                1:       v[i] = 1'b1;
                2:       v[i] = ((i + c) % 2) == 1;
                3:       v[i] = (c == 3) && (i < 37);
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // Upstream mux model: chunk selected by ctr, same cycle.
    always_comb chunk_in = pat(mode, int'(ctr));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_bundle(input logic [CW-1:0] thr);
        start  = 1'b1;
        thresh = thr;
        tick();
        start  = 1'b0;
        chk("busy_after_start", DW'(busy), DW'(1));
        chk("ctr_wait_hv", DW'(ctr), DW'(0));
    endtask

    task automatic feed_hv(input int m, input logic last);
        mode     = m;
        hv_valid = 1'b1;
        hv_last  = last;
        tick();
        for (int k = 0; k < NCH; k++) begin
            chk("accum_ctr", DW'(ctr), DW'(k));
            chk("hv_ack", DW'(hv_ack), DW'(k == NCH - 1));
            tick();
        end
        hv_valid = 1'b0;
        hv_last  = 1'b0;
    endtask

    task automatic emit(input int exp_mode, input int stall_idx, input int stall_len);
        out_ready = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk("stall_idx", DW'(out_idx), DW'(k));
                    chk("stall_chunk", out_chunk, pat(exp_mode, k));
                    chk("stall_valid", DW'(out_valid), DW'(1));
                    tick();
                end
                out_ready = 1'b1;
            end
            chk("out_valid", DW'(out_valid), DW'(1));
            chk("out_idx", DW'(out_idx), DW'(k));
            chk("out_chunk", out_chunk, pat(exp_mode, k));
            chk("done_early", DW'(done), DW'(0));
            tick();
        end
        out_ready = 1'b0;
        chk("done_pulse", DW'(done), DW'(1));
        chk("idle_after_emit", DW'(busy), DW'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; thresh = '0; hv_valid = 1'b0; hv_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_ctr", DW'(ctr), DW'(0));
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_ack", DW'(hv_ack), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_chunk", out_chunk, '0);
        chk("rst_idx", DW'(out_idx), DW'(0));
        rst = 1'b0;
        tick();

        // hv_valid is ignored while idle
        hv_valid = 1'b1;
        tick();
        chk("idle_ignores_hv", DW'(busy), DW'(0));
        hv_valid = 1'b0;

        // single alternating HV, thresh=1 reproduces input
        start_bundle(6'd1);
        feed_hv(2, 1'b1);
        emit(2, -1, 0);
        tick();
        chk("done_one_cycle", DW'(done), DW'(0));

        // ones, ones, zeros with thresh=2 -> all ones
        start_bundle(6'd2);
        feed_hv(1, 1'b0);
        feed_hv(1, 1'b0);
        feed_hv(0, 1'b1);
        emit(1, -1, 0);

        // same bundle with thresh=3 -> all zeros
        start_bundle(6'd3);
        feed_hv(1, 1'b0);
        feed_hv(1, 1'b0);
        feed_hv(0, 1'b1);
        emit(0, -1, 0);

        // 70 all-ones HVs, thresh=63: saturation, a wrap would leave count 6
        start_bundle(6'd63);
        for (int h = 0; h < 70; h++) feed_hv(1, h == 69);
        emit(1, -1, 0);

        // thresh=0 on a zero HV -> all ones; 5-cycle stall on chunk 4
        start_bundle(6'd0);
        feed_hv(0, 1'b1);
        emit(1, 4, 5);

        // reset mid-ACCUM at ctr=6
        start_bundle(6'd1);
        mode     = 1;
        hv_valid = 1'b1;
        hv_last  = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst_ctr", DW'(ctr), DW'(6));
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", DW'(busy), DW'(0));
        chk("midrst_ctr", DW'(ctr), DW'(0));
        chk("midrst_ack", DW'(hv_ack), DW'(0));
        chk("midrst_valid", DW'(out_valid), DW'(0));
        hv_valid = 1'b0;
        hv_last  = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_no_done", DW'(done), DW'(0));
        tick();
        start_bundle(6'd1);
        feed_hv(0, 1'b1);
        emit(0, -1, 0);

        // 37 ones in one chunk, thresh=1
        start_bundle(6'd1);
        feed_hv(3, 1'b1);
        emit(3, -1, 0);
`ifdef ENC_BUNDLE_DENSITY_EN
        chk("density", DW'(density), DW'(37));
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_chunk_bundler.md
Name: enc_chunk_bundler

Overview:
- Downstream consumer of the encoder chunk mux. Drives the 4-bit chunk select and receives a DIMS_PER_CC-bit slice of the bound hypervector each cycle.
- Accumulates per-dimension counts over a sequence of input hypervectors (sparse bundling), then thresholds the counts.
- Streams the bundled hypervector out one chunk per accepted cycle, towards AM/query storage.

Parameters:
HV_DIM, 5000, hypervector dimensionality
DIMS_PER_CC, 500, dimensions processed per clock (slice width)
NUM_CHUNKS, 10, HV_DIM/DIMS_PER_CC; sweep length; must fit in 4 bits
CNT_W, 6, per-dimension counter width; counters saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin new bundle; clears all counters, samples thresh; honoured in IDLE only
thresh  input  CNT_W  bundling threshold; output bit = (count >= thresh)
hv_valid  input  1  bound HV present on mux input; held with data stable until hv_ack
hv_last  input  1  qualifies hv_valid: this HV is the last of the bundle
hv_ack  output  1  one-cycle pulse on the final chunk cycle of an HV sweep
ctr  output  4  chunk select to mux, 0..NUM_CHUNKS-1
chunk_in  input  DIMS_PER_CC  mux output for the current ctr, same cycle
out_valid  output  1  out_chunk valid
out_ready  input  1  downstream accepts out_chunk
out_chunk  output  DIMS_PER_CC  thresholded bundle bits for chunk out_idx
out_idx  output  4  chunk index of out_chunk
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last output chunk is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; ctr=0; all counters 0; internal thresh register 0; last flag 0.
- Counter storage: NUM_CHUNKS*DIMS_PER_CC counters, each CNT_W bits. Counter [c*DIMS_PER_CC+i] pairs with chunk c, bit i.
- IDLE:
  - start=1: clear all counters in one cycle, register thresh, go WAIT_HV.
  - hv_valid is ignored in IDLE.
- WAIT_HV:
  - ctr=0.
  - hv_valid=1: register hv_last, go ACCUM. The first accumulation happens in the following cycle, with ctr=0.
- ACCUM, one chunk per cycle:
  - Every counter of chunk ctr with chunk_in[i]=1 increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - ctr increments each cycle.
  - When ctr==NUM_CHUNKS-1: assert hv_ack that cycle; ctr returns to 0; next state is EMIT if the registered last flag is set, else WAIT_HV.
  - Latency: exactly NUM_CHUNKS cycles per HV.
  - Upstream must hold the source HV stable from hv_valid until hv_ack.
- EMIT:
  - ctr drives the chunk index; out_idx=ctr; out_valid=1.
  - out_chunk[i] = (counter[ctr*DIMS_PER_CC+i] >= thresh_reg).
  - out_valid && out_ready: advance ctr. On acceptance of chunk NUM_CHUNKS-1: pulse done next cycle, ctr=0, go IDLE.
  - out_ready=0: out_chunk, out_idx and ctr hold; stalls are unbounded.
  - Output is combinational from registered counters and ctr; no added latency.
- start outside IDLE: ignored. hv_valid outside WAIT_HV: ignored.
- thresh=0: all output bits 1. thresh=2^CNT_W-1: only saturated dims set.
- A bundle of one HV with thresh=1 reproduces the input HV exactly.
- Reset asserted mid-operation: immediately returns to the reset values above; any partial bundle is discarded; no done pulse.

Optional Feature:
- Macro ENC_BUNDLE_DENSITY_EN.
- Defined:
  - Adds output port density, width ceil(log2(HV_DIM+1)) (13 for defaults).
  - Popcount of each accepted out_chunk is accumulated during EMIT.
  - density is registered and updated in the same cycle done pulses; held until the next done.
  - Cleared by reset and by an accepted start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single HV, thresh=1, chunk_in pattern = ctr-dependent (bit i = (i+ctr)%2), hv_last=1 -> hv_ack on 10th ACCUM cycle; 10 out chunks equal the input chunks; out_idx 0..9; done 1 cycle after 10th accept.
- Three HVs (all-ones, all-ones, all-zeros), thresh=2 -> every output bit 1; thresh=3 -> every output bit 0.
- 70 all-ones HVs, CNT_W=6, thresh=63 -> counters saturate at 63, no wrap, all output bits 1.
- EMIT with out_ready low for 5 cycles on chunk 4 -> out_chunk and out_idx=4 stable through the stall; done delayed by 5 cycles.
- Reset asserted mid-ACCUM (ctr=6), then a new start with a one-HV bundle of all-zeros, thresh=1 -> all outputs 0; no residual counts, every out bit 0.
- With ENC_BUNDLE_DENSITY_EN: single HV with 37 ones, thresh=1 -> density=37 when done pulses.
